// File: rtl/cmp_rr_scheduler.sv
//----------------------------------------------------------------------------
// cmp_rr_scheduler : four requesters share one registered unsigned comparator
//                    through a round-robin arbiter (IDLE -> CMP -> DONE).
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module cmp_rr_scheduler #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_i,
    input  logic [R*N-1:0] a_bus_i,
    input  logic [R*N-1:0] b_bus_i,
    output logic [R-1:0]   ack_o,
    output logic [1:0]     grant_id_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           a_greater_o,
    output logic           a_equal_o,
    output logic           a_lesser_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic [1:0]   grant_q;
    logic [1:0]   last_grant_q;
    logic [N-1:0] op_a_q;
    logic [N-1:0] op_b_q;
    logic [2:0]   flags_q;

    logic         win_valid;
    logic [1:0]   win_idx;
    logic [1:0]   cand;

    // Search starts one past the last grant and wraps naturally in 2 bits.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= R; k++) begin
            cand = last_grant_q + k[1:0];
            if (!win_valid && req_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_valid) state_d = S_CMP;
            S_CMP:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_o  = '0;
        done_o = 1'b0;
        busy_o = 1'b0;
        case (state_q)
            S_CMP: begin
                busy_o = 1'b1;
            end
            S_DONE: begin
                busy_o         = 1'b1;
                done_o         = 1'b1;
                ack_o[grant_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            op_a_q       <= '0;
            op_b_q       <= '0;
            flags_q      <= 3'b000;
        end else begin
            if (state_q == S_IDLE && win_valid) begin
                grant_q <= win_idx;
                op_a_q  <= a_bus_i[win_idx*N +: N];
                op_b_q  <= b_bus_i[win_idx*N +: N];
            end
            if (state_q == S_CMP) begin
                flags_q <= {op_a_q > op_b_q, op_a_q == op_b_q, op_a_q < op_b_q};
            end
            if (state_q == S_DONE) begin
                last_grant_q <= grant_q;
            end
        end
    end

    assign grant_id_o  = grant_q;
    assign a_greater_o = flags_q[2];
    assign a_equal_o   = flags_q[1];
    assign a_lesser_o  = flags_q[0];

endmodule

`default_nettype wire

// File: tb/tb_cmp_rr_scheduler.sv
//----------------------------------------------------------------------------
// tb_cmp_rr_scheduler : directed vectors and hand-written corner sequences.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_cmp_rr_scheduler;

    localparam int N = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [R-1:0]   req = '0;
    logic [R*N-1:0] a_bus = '0;
    logic [R*N-1:0] b_bus = '0;
    logic [R-1:0]   ack;
    logic [1:0]     grant_id;
    logic           busy;
    logic           done;
    logic           a_greater;
    logic           a_equal;
    logic           a_lesser;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  g;
        logic [2:0]  flags;   // {gt, eq, lt}
    } vec_t;

    vec_t vecs[7];

    cmp_rr_scheduler #(.N(N), .R(R)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .a_bus_i     (a_bus),
        .b_bus_i     (b_bus),
        .ack_o       (ack),
        .grant_id_o  (grant_id),
        .busy_o      (busy),
        .done_o      (done),
        .a_greater_o (a_greater),
        .a_equal_o   (a_equal),
        .a_lesser_o  (a_lesser)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int         ack_cnt;
    int         ack_cyc[$];
    logic [1:0] ack_idx[$];

    initial begin
        vecs[0] = '{4'b0100, {8'd0, 8'd200, 8'd9, 8'd9},     {8'd5, 8'd17, 8'd50, 8'd9},   2'd2, 3'b100};
        vecs[1] = '{4'b0010, {8'd1, 8'd1, 8'd255, 8'd3},     {8'd1, 8'd2, 8'd255, 8'd1},   2'd1, 3'b010};
        vecs[2] = '{4'b0010, {8'd9, 8'd9, 8'd0, 8'd9},       {8'd9, 8'd9, 8'd255, 8'd9},   2'd1, 3'b001};
        vecs[3] = '{4'b1111, {8'd7, 8'd10, 8'd7, 8'd7},      {8'd1, 8'd10, 8'd1, 8'd1},    2'd2, 3'b010};
        vecs[4] = '{4'b0011, {8'd0, 8'd0, 8'd0, 8'd1},       {8'd5, 8'd5, 8'd5, 8'd0},     2'd0, 3'b100};
        vecs[5] = '{4'b1001, {8'd128, 8'd0, 8'd0, 8'd0},     {8'd127, 8'd9, 8'd9, 8'd9},   2'd3, 3'b100};
        vecs[6] = '{4'b1111, {8'd200, 8'd200, 8'd200, 8'd127}, {8'd1, 8'd1, 8'd1, 8'd128}, 2'd0, 3'b001};

        // Reset values, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_flags", 32'({a_greater, a_equal, a_lesser}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            req   = vecs[i].req;
            a_bus = vecs[i].a;
            b_bus = vecs[i].b;
            @(posedge clk); #1;
            chk($sformatf("v%0d_grant", i), 32'(grant_id), 32'(vecs[i].g));
            chk($sformatf("v%0d_busy_cmp", i), 32'(busy), 32'h1);
            chk($sformatf("v%0d_ack_cmp", i), 32'(ack), 32'h0);
            @(negedge clk);
            req   = '0;
            a_bus = ~vecs[i].a;
            b_bus = ~vecs[i].b;
            @(posedge clk); #1;
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(4'b0001 << vecs[i].g));
            chk($sformatf("v%0d_done", i), 32'(done), 32'h1);
            chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'h1);
            chk($sformatf("v%0d_flags", i), 32'({a_greater, a_equal, a_lesser}), 32'(vecs[i].flags));
            @(posedge clk); #1;
            chk($sformatf("v%0d_ack_idle", i), 32'(ack), 32'h0);
            chk($sformatf("v%0d_done_idle", i), 32'(done), 32'h0);
            chk($sformatf("v%0d_busy_idle", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_flags_hold", i), 32'({a_greater, a_equal, a_lesser}), 32'(vecs[i].flags));
            @(negedge clk);
        end

        // Full contention from reset: grants 0,1,2,3 spaced three cycles.
        do_reset();
        req     = 4'b1111;
        ack_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ack != 4'b0000) begin
                chk($sformatf("cont_onehot_c%0d", c), 32'($onehot(ack)), 32'h1);
                ack_cnt++;
                ack_cyc.push_back(c);
                ack_idx.push_back(grant_id);
            end
        end
        @(negedge clk);
        req = '0;
        chk("cont_ack_count", 32'(ack_cnt), 32'd4);
        for (int j = 0; j < ack_idx.size() && j < 4; j++) begin
            chk($sformatf("cont_order_%0d", j), 32'(ack_idx[j]), 32'(j));
            chk($sformatf("cont_cycle_%0d", j), 32'(ack_cyc[j]), 32'(1 + 3*j));
        end

        // Fairness after wrap: last grant is 3, requesters 0 and 3 pending.
        req = 4'b1001;
        @(posedge clk); #1;
        chk("fair_first_grant", 32'(grant_id), 32'h0);
        @(posedge clk); #1;
        chk("fair_first_ack", 32'(ack), 32'b0001);
        @(posedge clk);
        @(posedge clk); #1;
        chk("fair_second_grant", 32'(grant_id), 32'h3);
        @(posedge clk); #1;
        chk("fair_second_ack", 32'(ack), 32'b1000);
        @(negedge clk);
        req = '0;
        @(posedge clk);
        @(negedge clk);

        // Operand stability: A0 changes after the grant edge.
        req   = 4'b0001;
        a_bus = {8'd0, 8'd0, 8'd0, 8'd5};
        b_bus = {8'd0, 8'd0, 8'd0, 8'd100};
        @(posedge clk); #1;
        chk("stab_grant", 32'(grant_id), 32'h0);
        @(negedge clk);
        req   = '0;
        a_bus = {8'd0, 8'd0, 8'd0, 8'd250};
        @(posedge clk); #1;
        chk("stab_ack", 32'(ack), 32'b0001);
        chk("stab_flags", 32'({a_greater, a_equal, a_lesser}), 32'b001);
        @(posedge clk);
        @(negedge clk);

        // Reset in CMP aborts immediately; first grant afterwards favours 1.
        req   = 4'b0100;
        a_bus = {8'd0, 8'd9, 8'd0, 8'd0};
        b_bus = {8'd0, 8'd3, 8'd0, 8'd0};
        @(posedge clk); #1;
        chk("abort_busy_pre", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1010;
        #1;
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_flags", 32'({a_greater, a_equal, a_lesser}), 32'h0);
        chk("abort_grant", 32'(grant_id), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_grant", 32'(grant_id), 32'h1);
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        chk("post_rst_ack", 32'(ack), 32'b0010);
        chk("post_rst_done", 32'(done), 32'h1);
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
